avg_pool_tile_ctrl: RTL
=======================

Name: avg_pool_tile_ctrl

Overview:
Sequences the combinational 2x2 average-pooling block (avg_pool) over a streamed pixel input. Each tile of WIDTH_IN x WIDTH_IN 32-bit pixels arrives in raster order through a valid/ready handshake and is collected into a tile buffer. The pooled result is registered once. The (WIDTH_IN/2)^2 outputs are then streamed out in raster order with valid/ready and a last marker. The block sits between the DDR3 read path and the downstream feature-map writer.

Parameters:
WIDTH_IN, 8, tile edge in pixels; must be even and >= 2
WIDTH_OUT, WIDTH_IN/2, pooled tile edge; derived, not overridden
CNT_W, 16, width of the tiles_done counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_data holds a valid pixel
in_ready  out  1  block accepts a pixel this cycle
in_data  in  32  unsigned pixel, raster order within the tile
out_valid  out  1  out_data holds a valid pooled pixel
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  32  unsigned pooled pixel, raster order
out_last  out  1  high with the final pooled pixel of a tile
busy  out  1  high in POOL or DRAIN, or when LOAD has accepted at least one pixel
tiles_done  out  CNT_W  count of fully drained tiles; wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - in_ready=0 during the reset cycle, 1 from the first cycle after reset is deasserted.
  - out_valid=0, out_last=0, out_data=0, busy=0, tiles_done=0.
  - Internal state: FSM=LOAD, counters=0.
- Reset mid-tile: the partial tile is discarded and none of its outputs are emitted. Buffer contents need not be cleared.
- FSM states: LOAD, POOL, DRAIN.
- LOAD:
  - in_ready=1.
  - On each handshake (in_valid & in_ready), in_data is written to buf[in_cnt] and in_cnt increments. Buffer index k = col + row*WIDTH_IN.
  - When the handshake with in_cnt = WIDTH_IN^2-1 occurs: in_cnt resets to 0 and the FSM goes to POOL.
- POOL:
  - in_ready=0. Lasts exactly one cycle.
  - avg_pool output is captured into the result register res[0..WIDTH_OUT^2-1]; out_cnt resets to 0.
  - Then go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=res[out_cnt], out_last=(out_cnt==WIDTH_OUT^2-1), in_ready=0.
  - On each handshake (out_valid & out_ready), out_cnt increments.
  - On the handshake with out_last=1: tiles_done increments and the FSM goes to LOAD. out_valid drops the next cycle.
- Latency: if the last input handshake occurs in cycle N, then POOL is cycle N+1 and the first out_valid is cycle N+2. Minimum tile period is WIDTH_IN^2 + 1 + WIDTH_OUT^2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Input stall: in_valid=0 in LOAD stalls the block with no state change.
- No overlap: load of the next tile does not begin until the previous tile has fully drained.
- Arithmetic, per output (i,j), where p00..p11 are the four inputs of the 2x2 window:
  - res[i + j*WIDTH_OUT] = (p00>>2)+(p01>>2)+(p10>>2)+(p11>>2), unsigned, 32-bit.
  - Each term is truncated before the sum. This cannot overflow.
  - Window inputs are buf[2i+2j*WIDTH_IN], buf[+1], buf[+WIDTH_IN], buf[+WIDTH_IN+1].
- tiles_done wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package pool_pkg holds:
  - PIX_W=32;
  - typedef pixel_t (logic [31:0]);
  - enum pool_state_t {LOAD, POOL, DRAIN}.
- One sub-module: the existing avg_pool, instantiated with WIDTH_IN passed through, driven by the tile buffer and feeding the result register.
- Counters and the FSM stay in avg_pool_tile_ctrl.

Test Plan:
1. WIDTH_IN=8; stream pixels 4*k for k=0..63, out_ready=1 -> 16 outputs. out[0]=(0+4+32+36)/4=18. out[i+4j]=8i+64j+18. out_last only on the 16th output. tiles_done=1.
2. All inputs 32'hFFFF_FFFF -> each output is 4*(32'h3FFF_FFFF)=32'hFFFF_FFFC, verifying truncate-then-sum.
3. Inputs {1,1,1,1} in the first window, others 0 -> out[0]=0 (each 1>>2=0); all other outputs 0.
4. Hold out_ready=0 for 5 cycles after the first out_valid -> out_data and out_last stable, and in_ready=0 throughout. Release -> all 16 outputs in order.
5. Random in_valid gaps with 3 back-to-back tiles -> exact expected outputs per tile, tiles_done=3, in_ready never high during POOL/DRAIN.
6. Assert reset after 30 pixels of a tile, then send a fresh 64-pixel tile -> outputs reflect only the fresh tile; tiles_done=1; no outputs emitted from the aborted tile.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types for the 2x2 average-pooling tile path.
package pool_pkg;
  localparam int PIX_W = 32;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    LOAD,
    POOL,
    DRAIN
  } pool_state_t;
endpackage

// File: rtl/avg_pool.sv
// Combinational 2x2 average pooling over one WIDTH_IN x WIDTH_IN tile.
// Each of the four window terms is shifted down by 2 before the sum, so the
// 32-bit result can never overflow.
module avg_pool
  import pool_pkg::*;
#(
  parameter int WIDTH_IN = 8,
  localparam int WIDTH_OUT = WIDTH_IN / 2
) (
  input  pixel_t [WIDTH_IN*WIDTH_IN-1:0]   tile,
  output pixel_t [WIDTH_OUT*WIDTH_OUT-1:0] pooled
);

  // One adder tree per output window; i is the output column, j the output row.
  for (genvar j = 0; j < WIDTH_OUT; j++) begin : g_row
    for (genvar i = 0; i < WIDTH_OUT; i++) begin : g_col
      localparam int B = 2*i + 2*j*WIDTH_IN;
      assign pooled[i + j*WIDTH_OUT] = (tile[B]            >> 2)
                                     + (tile[B+1]          >> 2)
                                     + (tile[B+WIDTH_IN]   >> 2)
                                     + (tile[B+WIDTH_IN+1] >> 2);
    end
  end

endmodule

// File: rtl/avg_pool_tile_ctrl.sv
// Tile sequencer around avg_pool: collects a raster-order tile, pools it in a
// single cycle, then streams the pooled tile out with valid/ready and last.
module avg_pool_tile_ctrl
  import pool_pkg::*;
#(
  parameter int WIDTH_IN = 8,
  parameter int CNT_W    = 16,
  localparam int WIDTH_OUT = WIDTH_IN / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] tiles_done
);

  localparam int N_IN   = WIDTH_IN * WIDTH_IN;
  localparam int N_OUT  = WIDTH_OUT * WIDTH_OUT;
  localparam int IN_CW  = $clog2(N_IN);
  localparam int OUT_CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  pool_state_t             state;
  logic [IN_CW-1:0]        in_cnt;
  logic [OUT_CW-1:0]       out_cnt;
  logic [OUT_CW-1:0]       out_nxt;
  pixel_t [N_IN-1:0]       tile_buf;
  pixel_t [N_OUT-1:0]      pooled;
  pixel_t [N_OUT-1:0]      res;
  logic                    in_last;

  // Ready is gated by reset so no pixel is taken during the reset cycle.
  assign in_ready = (state == LOAD) && !reset;
  assign busy     = (state != LOAD) || (in_cnt != '0);
  assign in_last  = (in_cnt == IN_CW'(N_IN - 1));
  assign out_nxt  = out_cnt + 1'b1;

  avg_pool #(.WIDTH_IN(WIDTH_IN)) u_avg_pool (
    .tile   (tile_buf),
    .pooled (pooled)
  );

  // Tile buffer: written at the raster index of each accepted pixel.
  // A reset mid-tile leaves stale data; it is fully overwritten before use.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) tile_buf[in_cnt] <= in_data;
  end

  // Pooled result is registered once, in the POOL cycle.
  always_ff @(posedge clk) begin
    if (state == POOL) res <= pooled;
  end

  // Main FSM with registered output-side signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      in_cnt     <= '0;
      out_cnt    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      tiles_done <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (in_last) begin
              in_cnt <= '0;
              state  <= POOL;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        POOL: begin
          // Present the first pooled pixel straight from the pooling logic
          // so out_data is valid in the first DRAIN cycle.
          out_cnt   <= '0;
          out_valid <= 1'b1;
          out_data  <= pooled[0];
          out_last  <= (N_OUT == 1);
          state     <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              tiles_done <= tiles_done + 1'b1;
              state      <= LOAD;
            end else begin
              out_cnt  <= out_nxt;
              out_data <= res[out_nxt];
              out_last <= (out_nxt == OUT_CW'(N_OUT - 1));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
